mem_lsu: RTL and testbench

Load/store initiator that drives the data-RAM port on behalf of the pipeline MEM stage. It accepts one load or store request at a time and converts byte, halfword and word operations into RAM chip-enable, write-enable, word address and byte-lane select signals. It returns sign- or zero-extended load data, or a store completion, together with an address-error flag. While an access is in flight it holds the pipeline with a stall output.

---
 rtl/mem_lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_lsu.sv | 120 ++++++++++++
 tb/tb_mem_lsu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared op codes, FSM encodings and op decode helpers for mem_lsu
package mem_lsu_pkg;

  localparam int LSU_OP_W = 4;
  typedef logic [LSU_OP_W-1:0] lsu_op_bus_t;

  localparam lsu_op_bus_t OP_NOP = 4'd0;
  localparam lsu_op_bus_t OP_LB  = 4'd1;
  localparam lsu_op_bus_t OP_LBU = 4'd2;
  localparam lsu_op_bus_t OP_LH  = 4'd3;
  localparam lsu_op_bus_t OP_LHU = 4'd4;
  localparam lsu_op_bus_t OP_LW  = 4'd5;
  localparam lsu_op_bus_t OP_SB  = 4'd6;
  localparam lsu_op_bus_t OP_SH  = 4'd7;
  localparam lsu_op_bus_t OP_SW  = 4'd8;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

  function automatic logic op_is_load(input lsu_op_bus_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input lsu_op_bus_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Non-memory codes report SZ_BYTE; callers gate on op_is_load/op_is_store.
  function automatic lsu_size_e op_size(input lsu_op_bus_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - big-endian lane select, store replication and load extension
module lsu_align
  import mem_lsu_pkg::*;
(
  input  lsu_op_bus_t op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sgn;

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    // Address 0 is the most significant byte.
    case (addr_lo)
      2'd0:    lane_b = rdata[31:24];
      2'd1:    lane_b = rdata[23:16];
      2'd2:    lane_b = rdata[15:8];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    sgn    = (op == OP_LB) || (op == OP_LH);
    case (op_size(op))
      SZ_HALF: begin
        sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sgn & lane_h[15]}}, lane_h};
      end
      SZ_WORD: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: begin
        sel       = 4'b1000 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & lane_b[7]}}, lane_b};
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store FSM driving the data RAM; LSU_ADDR_CHECK_EN enables misalignment errors
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_exc,
  output logic              stall_o,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic [1:0]  state;
  lsu_op_bus_t op_q;
  logic [1:0]  addr_lo_q;
  lsu_op_bus_t a_op;
  logic [1:0]  a_addr_lo;
  logic [3:0]  a_sel;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        addr_err;
  logic        go_access;

  assign req_ready  = (state == ST_IDLE);
  assign stall_o    = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // One aligner serves both phases: request fields in IDLE, latched fields in ACCESS.
  assign a_op      = (state == ST_IDLE) ? req_op : op_q;
  assign a_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .op        (a_op),
    .addr_lo   (a_addr_lo),
    .wdata     (req_wdata),
    .rdata     (ram_rdata),
    .sel       (a_sel),
    .wdata_rep (a_wdata),
    .rdata_ext (a_rdata)
  );

`ifdef LSU_ADDR_CHECK_EN
  always_comb begin
    addr_err = 1'b0;
    if (op_is_load(req_op) || op_is_store(req_op)) begin
      case (op_size(req_op))
        SZ_HALF: addr_err = req_addr[0];
        SZ_WORD: addr_err = (req_addr[1:0] != 2'b00);
        default: addr_err = 1'b0;
      endcase
    end
  end
`else
  assign addr_err = 1'b0;
`endif

  assign go_access = (op_is_load(req_op) || op_is_store(req_op)) && !addr_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      addr_lo_q <= 2'b00;
      resp_data <= 32'h0;
      resp_exc  <= 1'b0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_sel   <= 4'b0000;
      ram_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_lo_q <= req_addr[1:0];
            if (go_access) begin
              state     <= ST_ACCESS;
              ram_ce    <= 1'b1;
              ram_we    <= op_is_store(req_op);
              ram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              ram_sel   <= a_sel;
              ram_wdata <= op_is_store(req_op) ? a_wdata : 32'h0;
            end else begin
              state     <= ST_RESP;
              resp_data <= 32'h0;
              resp_exc  <= addr_err;
            end
          end
        end
        ST_ACCESS: begin
          state     <= ST_RESP;
          resp_data <= op_is_load(op_q) ? a_rdata : 32'h0;
          resp_exc  <= 1'b0;
          ram_ce    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_sel   <= 4'b0000;
          ram_wdata <= 32'h0;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu with a big-endian RAM model
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic        stall_o;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_exc(resp_exc),
    .stall_o(stall_o),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = (ram_ce && !ram_we) ? mem[ram_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      if (ram_sel[3]) mem[ram_addr[7:2]][31:24] <= ram_wdata[31:24];
      if (ram_sel[2]) mem[ram_addr[7:2]][23:16] <= ram_wdata[23:16];
      if (ram_sel[1]) mem[ram_addr[7:2]][15:8]  <= ram_wdata[15:8];
      if (ram_sel[0]) mem[ram_addr[7:2]][7:0]   <= ram_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
  task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] data, output logic exc, output int lat,
                         output bit ce_seen, output bit busy_ok);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; ce_seen = 1'b0; busy_ok = 1'b1;
    while (!resp_valid && lat < 6) begin
      ce_seen |= ram_ce;
      busy_ok &= (!req_ready && stall_o);
      @(posedge clk); #1;
      lat++;
    end
    ce_seen |= ram_ce;
    busy_ok &= (!req_ready && stall_o);
    data = resp_data;
    exc  = resp_exc;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    bit          ce_seen;
    bit          busy_ok;
    bit          rv_seen;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1]  = 32'hCAFEF00D;
    mem[3]  = 32'h11223344;
    mem[8]  = 32'h80FF7F01;
    mem[16] = 32'h01020304;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_exc", {31'h0, resp_exc}, 32'h0);
    check("rst_ram_ctl", {28'h0, ram_ce, ram_we, 2'b00}, 32'h0);
    check("rst_ram_sel", {28'h0, ram_sel}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // SB 0x13: lane 0001, replicated byte, RAM signals one cycle after acceptance
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h13; req_wdata = 32'h000000A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("sb_ce", {31'h0, ram_ce}, 32'h1);
    check("sb_we", {31'h0, ram_we}, 32'h1);
    check("sb_sel", {28'h0, ram_sel}, 32'h1);
    check("sb_wdata", ram_wdata, 32'hA5A5A5A5);
    check("sb_addr", ram_addr, 32'h10);
    check("sb_busy", {30'h0, req_ready, stall_o}, 32'h1);
    check("sb_no_early_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    check("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("sb_resp_data", resp_data, 32'h0);
    check("sb_ram_idle", {28'h0, ram_sel}, 32'h0);
    check("sb_mem", mem[4], 32'h000000A5);
    @(posedge clk); #1;
    check("sb_resp_pulse", {31'h0, resp_valid}, 32'h0);
    check("sb_idle_ready", {31'h0, req_ready}, 32'h1);

    run_req(OP_LB, 32'h20, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("lb_data", d, 32'hFFFFFF80);
    check("lb_lat", lat, 32'd2);
    run_req(OP_LBU, 32'h20, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("lbu_data", d, 32'h00000080);
    run_req(OP_LH, 32'h22, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("lh_data", d, 32'h00007F01);
    run_req(OP_LHU, 32'h20, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("lhu_data", d, 32'h000080FF);
    run_req(OP_LB, 32'h23, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("lb3_data", d, 32'h00000001);
    run_req(OP_LH, 32'h20, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("lh_neg_data", d, 32'hFFFF80FF);

    // Halfword stores: addr[1]=0 hits the upper half, addr[1]=1 the lower half
    run_req(OP_SH, 32'h0C, 32'h00001234, d, e, lat, ce_seen, busy_ok);
    check("sh0_busy", {31'h0, busy_ok}, 32'h1);
    check("sh0_lat", lat, 32'd2);
    run_req(OP_LW, 32'h0C, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("sh0_lw", d, 32'h12343344);
    check("lw_busy", {31'h0, busy_ok}, 32'h1);
    run_req(OP_SH, 32'h0E, 32'hABCD5678, d, e, lat, ce_seen, busy_ok);
    run_req(OP_LW, 32'h0C, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("sh2_lw", d, 32'h12345678);

    run_req(OP_LW, 32'h06, 32'h0, d, e, lat, ce_seen, busy_ok);
`ifdef LSU_ADDR_CHECK_EN
    check("mis_exc", {31'h0, e}, 32'h1);
    check("mis_lat", lat, 32'd1);
    check("mis_no_ce", {31'h0, ce_seen}, 32'h0);
    check("mis_data", d, 32'h0);
`else
    check("mis_exc", {31'h0, e}, 32'h0);
    check("mis_lat", lat, 32'd2);
    check("mis_data", d, 32'hCAFEF00D);
`endif

    // Reset in the ACCESS cycle of a word store
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsw_we_before", {31'h0, ram_we}, 32'h1);
    rst = 1'b0;
    #1;
    check("rsw_we_async", {31'h0, ram_we}, 32'h0);
    check("rsw_ce_async", {31'h0, ram_ce}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv_seen |= resp_valid;
      @(posedge clk); #1;
    end
    check("rsw_no_resp", {31'h0, rv_seen}, 32'h0);
    check("rsw_mem", mem[16], 32'h01020304);

    run_req(4'hF, 32'h20, 32'h0, d, e, lat, ce_seen, busy_ok);
    check("unk_lat", lat, 32'd1);
    check("unk_data", d, 32'h0);
    check("unk_exc", {31'h0, e}, 32'h0);
    check("unk_no_ce", {31'h0, ce_seen}, 32'h0);

    // Back-to-back: held req_valid is taken only once IDLE is re-entered
    req_valid = 1'b1; req_op = 4'hF; req_addr = 32'h0;
    @(posedge clk); #1;
    check("b2b_resp", {31'h0, resp_valid}, 32'h1);
    check("b2b_not_ready", {31'h0, req_ready}, 32'h0);
    req_op = OP_LW; req_addr = 32'h20;
    @(posedge clk); #1;
    check("b2b_ready", {31'h0, req_ready}, 32'h1);
    check("b2b_pulse_low", {31'h0, resp_valid}, 32'h0);
    check("b2b_no_ce", {31'h0, ram_ce}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_ce", {31'h0, ram_ce}, 32'h1);
    check("b2b_addr", ram_addr, 32'h20);
    @(posedge clk); #1;
    check("b2b_lw", resp_data, 32'h80FF7F01);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
